// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus targets: FSM state encoding,
// default bus widths and the encoding of the bus_mode field.
package serial_bus_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 8;

  localparam logic BUS_MODE_ADDR = 1'b0;
  localparam logic BUS_MODE_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_RD_FETCH,
    ST_RD_TX,
    ST_ACK,
    ST_SKIP
  } tgt_state_e;

endpackage

// File: rtl/serial_mem_target_mem.sv
// Local storage for serial_mem_target: single-port synchronous RAM with one
// write port and registered read data. Contents are never reset.
module target_mem #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/serial_mem_target.sv
// Memory-backed, immediate-response serial bus target: deserializes address
// and write data LSB first, writes or reads local RAM and serializes read data.
module serial_mem_target
  import serial_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-MEM_ADDR_WIDTH-1:0] ADDR_PREFIX = 4'b1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_data_in,
  input  logic bus_data_in_valid,
  input  logic bus_mode,
  input  logic bus_init_rw,
  input  logic bus_init_ready,
  output logic bus_data_out,
  output logic bus_data_out_valid,
  output logic bus_target_ready,
  output logic bus_target_ack
);

  localparam int PFX_W  = ADDR_WIDTH - MEM_ADDR_WIDTH;
  localparam int CNT_W  = $clog2(ADDR_WIDTH);
  localparam int DIDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  tgt_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic dout_q, dout_d;
  logic dvld_q, dvld_d;
  logic ack_q, ack_d;
  logic rdy_q, rdy_d;

  target_mem #(
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (state_q == ST_WRITE),
    .re_i    (state_q == ST_RD_FETCH),
    .addr_i  (addr_q[MEM_ADDR_WIDTH-1:0]),
    .wdata_i (data_q),
    .rdata_o (rdata)
  );

  // Control state: cleared asynchronously so a reset mid-transfer drops everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      dvld_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_data_in_valid && bus_mode == BUS_MODE_ADDR) begin
          addr_d[0] = bus_data_in;
          cnt_d     = CNT_W'(1);
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus_data_in_valid) begin
          if (bus_mode != BUS_MODE_ADDR) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            addr_d[cnt_q] = bus_data_in;
            if (cnt_q == ADDR_LAST) begin
              cnt_d = '0;
              // Prefix includes the bit arriving this cycle, hence addr_d.
              if (addr_d[ADDR_WIDTH-1 -: PFX_W] == ADDR_PREFIX) begin
                state_d = bus_init_rw ? ST_DATA : ST_RD_FETCH;
              end else begin
                state_d = bus_init_rw ? ST_SKIP : ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_DATA: begin
        if (bus_data_in_valid) begin
          if (bus_mode != BUS_MODE_DATA) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            data_d[cnt_q[DIDX_W-1:0]] = bus_data_in;
            if (cnt_q == DATA_LAST) begin
              cnt_d   = '0;
              state_d = ST_WRITE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_WRITE:    state_d = ST_ACK;
      ST_RD_FETCH: begin
        state_d = ST_RD_TX;
        cnt_d   = '0;
      end
      ST_RD_TX: begin
        if (bus_init_ready) begin
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = ST_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ACK:      state_d = ST_IDLE;
      ST_SKIP: begin
        if (bus_data_in_valid) begin
          if (bus_mode != BUS_MODE_DATA || cnt_q == DATA_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-state: a stalled read holds the last driven bit with valid low.
  always_comb begin
    dout_d = dout_q;
    dvld_d = 1'b0;
    ack_d  = (state_q == ST_ACK);
    rdy_d  = (state_d inside {ST_IDLE, ST_ADDR, ST_DATA, ST_SKIP});
    if (state_q == ST_RD_TX && bus_init_ready) begin
      dout_d = rdata[cnt_q[DIDX_W-1:0]];
      dvld_d = 1'b1;
    end
  end

  assign bus_data_out       = dout_q;
  assign bus_data_out_valid = dvld_q;
  assign bus_target_ack     = ack_q;
  assign bus_target_ready   = rdy_q;

endmodule

// File: tb/tb_serial_mem_target.sv
// Scoreboard bench for serial_mem_target: stimulus pushes the expected read
// bits and acks (with their cycle) into a queue, a monitor pops and compares.
module tb_serial_mem_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_vld = 1'b0;
  logic mode = 1'b0;
  logic rw = 1'b0;
  logic init_rdy = 1'b1;
  logic dout, dout_vld, tgt_rdy, ack;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_ack;
    bit val;
    int at;
  } exp_t;
  exp_t expq[$];

  serial_mem_target u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus_data_in        (din),
    .bus_data_in_valid  (din_vld),
    .bus_mode           (mode),
    .bus_init_rw        (rw),
    .bus_init_ready     (init_rdy),
    .bus_data_out       (dout),
    .bus_data_out_valid (dout_vld),
    .bus_target_ready   (tgt_rdy),
    .bus_target_ack     (ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dout_vld) begin
          if (expq.size() == 0 || expq[0].is_ack) begin
            check("unexpected_data_valid", 32'(dout_vld), 32'd0);
          end else begin
            e = expq.pop_front();
            check("rd_bit", 32'(dout), 32'(e.val));
            check("rd_bit_cycle", cyc, e.at);
          end
        end
        if (ack) begin
          if (expq.size() == 0 || !expq[0].is_ack) begin
            check("unexpected_ack", 32'(ack), 32'd0);
          end else begin
            e = expq.pop_front();
            check("ack_cycle", cyc, e.at);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vld = 1'b0;
      din     = 1'b0;
    end
  endtask

  // Shift n bits LSB first; optional valid gap of gaplen cycles after bit gap_after.
  task automatic send_bits(input logic [15:0] v, input int n, input logic m, input logic r,
                           input int gap_after, input int gaplen, output int last);
    logic [15:0] vv;
    vv = v;
    last = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_vld = 1'b1;
      mode    = m;
      rw      = r;
      din     = vv[i];
      last    = cyc + 1;
      if (i == gap_after) idle(gaplen);
    end
  endtask

  task automatic write_txn(input logic [15:0] addr, input logic [7:0] data,
                           input bit hit, input int gap_after);
    int last;
    send_bits(addr, 16, 1'b0, 1'b1, gap_after, 3, last);
    send_bits({8'h00, data}, 8, 1'b1, 1'b1, -1, 0, last);
    if (hit) expq.push_back('{1'b1, 1'b0, last + 2});
    idle(8);
    check("wr_pending", expq.size(), 0);
  endtask

  task automatic read_txn(input logic [15:0] addr, input logic [7:0] exp_data,
                          input int stall_after, input int rst_at);
    int n;
    int extra;
    send_bits(addr, 16, 1'b0, 1'b0, -1, 0, n);
    for (int i = 0; i < 8; i++) begin
      extra = (stall_after >= 0 && i > stall_after) ? 2 : 0;
      expq.push_back('{1'b0, exp_data[i], n + 2 + i + extra});
    end
    expq.push_back('{1'b1, 1'b0, n + 10 + ((stall_after >= 0) ? 2 : 0)});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      din_vld = 1'b0;
      if (cyc == n + 3) check("busy_ready", 32'(tgt_rdy), 32'd0);
      if (stall_after >= 0 && cyc == n + 2 + stall_after) init_rdy = 1'b0;
      if (stall_after >= 0 && cyc == n + 4 + stall_after) init_rdy = 1'b1;
      if (rst_at >= 0 && cyc == n + 2 + rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_data_valid", 32'(dout_vld), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data_out", 32'(dout), 32'd0);
        check("rst_ready", 32'(tgt_rdy), 32'd1);
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    check("rd_pending", expq.size(), 0);
  endtask

  initial begin
    int last;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(dout), 32'd0);
    check("reset_data_valid", 32'(dout_vld), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_ready", 32'(tgt_rdy), 32'd1);
    rst_n = 1'b1;
    idle(2);

    // Write hit, then read back.
    write_txn(16'h800A, 8'h5C, 1'b1, -1);
    check("mem_00A", 32'(u_dut.u_mem.mem[12'h00A]), 32'h5C);
    read_txn(16'h800A, 8'h5C, -1, -1);

    // Prefix miss write is skipped without ack and leaves storage untouched.
    write_txn(16'h100A, 8'hA5, 1'b0, -1);
    read_txn(16'h800A, 8'h5C, -1, -1);

    // Gapped address and stalled read.
    write_txn(16'h8FFF, 8'h3C, 1'b1, 7);
    read_txn(16'h8FFF, 8'h3C, 3, -1);

    // Data-mode bit in the middle of the address aborts the transfer.
    send_bits(16'h800A, 5, 1'b0, 1'b1, -1, 0, last);
    send_bits(16'h0001, 1, 1'b1, 1'b1, -1, 0, last);
    idle(4);
    check("err_ready", 32'(tgt_rdy), 32'd1);
    check("err_pending", expq.size(), 0);
    write_txn(16'h8001, 8'h11, 1'b1, -1);
    read_txn(16'h8001, 8'h11, -1, -1);

    // Reset during read bit 4, then a clean read.
    read_txn(16'h800A, 8'h5C, -1, 4);
    idle(2);
    read_txn(16'h800A, 8'h5C, -1, -1);

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mem_target.md
# serial_mem_target

Memory-backed responder for the serial bus, the far end of `init_port`. It deserializes the 16-bit address and 8-bit write data shifted out by an initiator, decodes its own 4-bit address prefix, and then does one of two things. For a write, it commits the byte to local storage and acks. For a read, it fetches the byte, serializes it back on the return line and acks. It sits on the arbitrated bus beside `split_target_port`-style targets as a non-split (immediate-response) target.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: bus address width.
- `DATA_WIDTH`, 8: bus data width.
- `MEM_ADDR_WIDTH`, 12: local address bits, `addr[11:0]`. Depth is 2^12.
- `ADDR_PREFIX`, 4'b1000: required value of `addr[15:12]`.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bus_data_in` in 1: serial bit from the initiator.
- `bus_data_in_valid` in 1: `bus_data_in` is a valid bit this cycle.
- `bus_mode` in 1: field of the incoming bit. 0 = address, 1 = data.
- `bus_init_rw` in 1: 1 = write, 0 = read. Sampled with the last address bit.
- `bus_init_ready` in 1: initiator can accept read data.
- `bus_data_out` out 1: serial read-data bit.
- `bus_data_out_valid` out 1: `bus_data_out` is valid this cycle.
- `bus_target_ready` out 1: target can accept a new transfer.
- `bus_target_ack` out 1: one-cycle completion pulse.

## Operation
- Serial order is LSB first for both address and data.
- A bit is consumed only on a cycle where `bus_data_in_valid` is 1. Gaps of any length stall the shift counter.
- FSM states: IDLE, ADDR, DATA, WRITE, RD_FETCH, RD_TX, ACK, SKIP.
- IDLE → ADDR on the first valid bit with `bus_mode`=0. That bit is address bit 0.
- ADDR: shift 16 bits. On the 16th bit, the next state depends on prefix and `bus_init_rw`:
  - prefix match and `bus_init_rw`=1 → DATA.
  - prefix match and `bus_init_rw`=0 → RD_FETCH.
  - prefix mismatch and `bus_init_rw`=1 → SKIP.
  - prefix mismatch and `bus_init_rw`=0 → IDLE.
- DATA: shift 8 bits with `bus_mode`=1. After the 8th bit → WRITE.
- WRITE: `mem[addr[11:0]]` ← data, then → ACK.
- RD_FETCH: registered memory read, 1 cycle. Then → RD_TX.
- RD_TX: drive 8 bits, bit 0 first, one per cycle. Advance only while `bus_init_ready`=1. Otherwise hold the current bit and deassert `bus_data_out_valid`. After the 8th bit → ACK.
- ACK: `bus_target_ack`=1 for one cycle, then → IDLE.
- SKIP: consume 8 valid data bits without any storage or ack, then → IDLE.
- Protocol error: a valid bit whose `bus_mode` disagrees with the current state (ADDR/DATA/SKIP) aborts to IDLE. No write, no ack.
- A valid bit arriving in WRITE, RD_FETCH, RD_TX or ACK is ignored.
- `bus_target_ready`=1 in IDLE, ADDR, DATA and SKIP. It is 0 otherwise.

## Timing
- Reset values:
  - `bus_data_out`=0, `bus_data_out_valid`=0, `bus_target_ack`=0, `bus_target_ready`=1.
  - State IDLE, counters 0.
  - Memory contents are not reset.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous). Any partial write is discarded.
- Write: last data bit sampled at edge N. Memory is written at edge N+1. `bus_target_ack` is high from edge N+2 to edge N+3.
- Read: last address bit sampled at edge N. `bus_data_out_valid` is high from edge N+2 for 8 cycles (no stall). `bus_target_ack` is high the cycle after the last bit.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- `serial_bus_pkg` holds:
  - the state enum `tgt_state_e`;
  - `ADDR_WIDTH` and `DATA_WIDTH` defaults;
  - the `BUS_MODE_ADDR`/`BUS_MODE_DATA` constants.
- Sub-module `target_mem`: single-port synchronous RAM, one write port, registered read data. Parameters `MEM_ADDR_WIDTH` and `DATA_WIDTH`.
- Shift registers, counters and the FSM live in `serial_mem_target`.

## Test plan
- **Write hit.** Write 0x5C to 0x800A, valid contiguous.
  - Exactly one ack, at last data bit + 2 edges.
  - Internal `mem[0x00A]`=0x5C.
- **Read-back.** Read 0x800A.
  - Returns 0,0,1,1,1,0,1,0 on `bus_data_out` (valid 8 cycles starting at last address bit + 2).
  - Then exactly one ack.
- **Prefix miss.** Write 0xA5 to 0x100A, then read 0x800A.
  - No ack for the write.
  - Read returns 0x5C.
- **Gapped valid and stalled read.**
  - Write 0x3C to 0x8FFF with a 3-cycle valid gap after address bit 7.
  - Read it back with `bus_init_ready` low for 2 cycles after bit 3.
  - Returns 0x3C: 8 valid cycles, contiguous apart from the 2-cycle stall.
- **Protocol error.** Send a `bus_mode`=1 bit at address bit 5.
  - Returns to IDLE, no ack.
  - A following write of 0x11 to 0x8001 succeeds.
- **Reset mid-read.** Assert `rst_n`=0 during RD_TX bit 4.
  - `bus_data_out_valid` and ack drop at once.
  - After release, a read of 0x800A returns 0x5C.
